branch_resolve_unit: RTL and testbench

- Resolves conditional and unconditional branches for the RSAASIP core's fetch/PC logic.
- Takes the branch target address, branch opcode, zero flag and jump-enable from the decode/execute stage.
- Produces a registered taken flag and target address that the PC mux consumes one cycle later.

---
 rtl/branch_pkg.sv | 13 +
 rtl/branch_cond_eval.sv | 30 +++
 rtl/branch_resolve_unit.sv | 83 ++++++++
 tb/tb_branch_resolve_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve unit: default widths, branch
// opcodes and the width of the optional taken-branch statistics counter.
package branch_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_OP_W   = 3;
    localparam int unsigned STATS_W    = 16;

    localparam logic [DEF_OP_W-1:0] OP_BNE = 3'b100;
    localparam logic [DEF_OP_W-1:0] OP_BEQ = 3'b101;
    localparam logic [DEF_OP_W-1:0] OP_JMP = 3'b110;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: decides whether the branch
// presented this cycle is taken, from opcode, zero flag and jump enable.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned OP_W = DEF_OP_W
) (
    input  logic [OP_W-1:0] op,
    input  logic            z,
    input  logic            jenable,
    output logic            take
);

    logic cond;

    // Opcode decode; unknown codes are simply never taken.
    always_comb begin
        cond = 1'b0;
        case (op)
            OP_W'(OP_BNE): cond = ~z;
            OP_W'(OP_BEQ): cond = z;
            OP_W'(OP_JMP): cond = 1'b1;
            default:       cond = 1'b0;
        endcase
    end

    // jenable gates last so a disabled slot yields 0 even for an unknown op.
    assign take = jenable & cond;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registers the taken flag and branch target for the
// PC mux one cycle after the decode/execute stage presents them.
// Optional macro BRANCH_UNIT_STATS_EN adds a saturating taken-branch counter
// on output taken_count.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [OP_W-1:0]   op,
    input  logic              z,
    input  logic              jenable,
`ifdef BRANCH_UNIT_STATS_EN
    output logic [STATS_W-1:0] taken_count,
`endif
    output logic              b_taken,
    output logic [ADDR_W-1:0] out_addr
);

    logic              take;
    logic              b_taken_d, b_taken_q;
    logic [ADDR_W-1:0] out_addr_d, out_addr_q;

    branch_cond_eval #(
        .OP_W (OP_W)
    ) u_cond_eval (
        .op      (op),
        .z       (z),
        .jenable (jenable),
        .take    (take)
    );

    // Next state: flag follows take; target only loads on a taken branch.
    always_comb begin
        b_taken_d  = take;
        out_addr_d = out_addr_q;
        if (take) begin
            out_addr_d = address;
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_taken_q  <= 1'b0;
            out_addr_q <= '0;
        end else begin
            b_taken_q  <= b_taken_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign b_taken  = b_taken_q;
    assign out_addr = out_addr_q;

`ifdef BRANCH_UNIT_STATS_EN
    logic [STATS_W-1:0] taken_count_d, taken_count_q;

    // Saturating count of taken branches.
    always_comb begin
        taken_count_d = taken_count_q;
        if (take && (taken_count_q != {STATS_W{1'b1}})) begin
            taken_count_d = taken_count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_count_q <= '0;
        end else begin
            taken_count_q <= taken_count_d;
        end
    end

    assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes expected
// post-edge outputs into a queue, a monitor pops and compares after each edge.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic [9:0]  address;
    logic [2:0]  op;
    logic        z;
    logic        jenable;
    logic        b_taken;
    logic [9:0]  out_addr;
    logic [15:0] taken_count;

    typedef struct {
        logic        taken;
        logic [9:0]  addr;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int m_addr = 0;
    int m_cnt  = 0;

    branch_resolve_unit dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .op          (op),
        .z           (z),
        .jenable     (jenable),
`ifdef BRANCH_UNIT_STATS_EN
        .taken_count (taken_count),
`endif
        .b_taken     (b_taken),
        .out_addr    (out_addr)
    );

`ifndef BRANCH_UNIT_STATS_EN
    assign taken_count = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and push what the outputs must be after the edge.
    task automatic apply(input bit r, input int a, input int o, input bit zz, input bit j);
        bit   t;
        exp_t e;
        @(negedge clk);
        rst     = r;
        address = 10'(a);
        op      = 3'(o);
        z       = zz;
        jenable = j;
        t = j && ((o == 4 && !zz) || (o == 5 && zz) || (o == 6));
        if (r) begin
            t      = 0;
            m_addr = 0;
            m_cnt  = 0;
        end else if (t) begin
            m_addr = a;
            if (m_cnt < 65535) m_cnt++;
        end
        e.taken = t;
        e.addr  = 10'(m_addr);
        e.cnt   = 16'(m_cnt);
        exp_q.push_back(e);
    endtask

    // Monitor: compare after every rising edge that has an expectation queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("b_taken", int'(b_taken), int'(e.taken));
                check("out_addr", int'(out_addr), int'(e.addr));
`ifdef BRANCH_UNIT_STATS_EN
                check("taken_count", int'(taken_count), int'(e.cnt));
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; address = '0; op = '0; z = 1'b0; jenable = 1'b0;

        // Reset and directed vectors.
        apply(1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        apply(0, 25, 5, 1, 1);
        apply(0, 30, 5, 0, 1);
        apply(0, 60, 6, 0, 0);
        apply(0, 65, 6, 1, 1);
        apply(0, 1023, 4, 0, 1);
        apply(0, 500, 4, 1, 1);
        apply(0, 501, 3, 1, 1);
        // Disabled slot with every opcode.
        for (int o = 0; o < 8; o++) apply(0, 100 + o, o, o[0], 0);
        // Back-to-back taken branches.
        apply(0, 1, 6, 0, 1);
        apply(0, 2, 6, 1, 1);
        apply(0, 3, 4, 0, 1);
        // Mid-stream reset, then normal evaluation straight after.
        apply(1, 700, 6, 1, 1);
        apply(0, 0, 6, 1, 1);
        apply(0, 77, 0, 1, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 49) == 0), $urandom_range(0, 1023), $urandom_range(0, 7),
                  1'($urandom), ($urandom_range(0, 3) != 0));
        end

`ifdef BRANCH_UNIT_STATS_EN
        // Drive the counter into saturation and hold it there.
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) apply(0, i % 1024, 6, 0, 1);
        apply(0, 5, 2, 0, 1);
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
